// File: rtl/mod_reduce_stage_pkg.sv
// Shared widths, FSM encoding and chunk-offset helper for the modular reduction stage.
package mod_reduce_stage_pkg;

  localparam int WIDTH  = 384;
  localparam int CHUNK  = 64;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = $clog2(NCHUNK);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_SEL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Bit offset of chunk k inside a WIDTH-wide operand.
  function automatic int chunk_lsb(input logic [CNT_W-1:0] k);
    return int'(k) * CHUNK;
  endfunction

endpackage

// File: rtl/mod_reduce_stage_if.sv
// Request/result bundle between the modular adder, this stage and the field-op controller.
interface mod_reduce_stage_if;
  import mod_reduce_stage_pkg::*;

  logic             start;
  logic [WIDTH:0]   sum_in;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  modport master (
    output start, sum_in, modulus,
    input  result, busy, done
  );

  modport slave (
    input  start, sum_in, modulus,
    output result, busy, done
  );

endinterface

// File: rtl/mod_reduce_stage_chunk_sub.sv
// One CHUNK-bit slice of the S - M borrow chain.
module chunk_sub
  import mod_reduce_stage_pkg::*;
(
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_bin,
  output logic [CHUNK-1:0] o_d,
  output logic             o_bout
);

  logic [CHUNK:0] w_diff;

  // Extra top bit of the widened difference is the outgoing borrow.
  assign w_diff = {1'b0, i_a} - {1'b0, i_b} - {{CHUNK{1'b0}}, i_bin};
  assign o_d    = w_diff[CHUNK-1:0];
  assign o_bout = w_diff[CHUNK];

endmodule

// File: rtl/mod_reduce_stage.sv
// Conditional subtract S mod M (S < 2M), S - M computed CHUNK bits per cycle.
module mod_reduce_stage
  import mod_reduce_stage_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  mod_reduce_stage_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH:0]   r_s;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_result;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  int               w_lsb;
  logic [CHUNK-1:0] w_a;
  logic [CHUNK-1:0] w_b;
  logic [CHUNK-1:0] w_d;
  logic             w_bout;
  logic             w_accept;
  logic             w_last;
  logic             w_ge;

  assign w_lsb    = chunk_lsb(r_cnt);
  assign w_a      = r_s[w_lsb +: CHUNK];
  assign w_b      = r_m[w_lsb +: CHUNK];
  assign w_accept = bus.start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_last   = (r_cnt == LAST_CNT);
  // A set carry bit means S >= 2^WIDTH > M, so the subtract applies regardless of borrow.
  assign w_ge     = r_s[WIDTH] | ~r_borrow;

  chunk_sub u_chunk_sub (
    .i_a    (w_a),
    .i_b    (w_b),
    .i_bin  (r_borrow),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; DONE accepts a new start just like IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SUB;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SUB: begin
        if (w_last) begin
          w_state_nxt = ST_SEL;
        end else begin
          w_state_nxt = ST_SUB;
        end
      end
      ST_SEL: begin
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (w_accept) begin
          w_state_nxt = ST_SUB;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand capture, chunked subtract and final select.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s      <= '0;
      r_m      <= '0;
      r_d      <= '0;
      r_result <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_s      <= bus.sum_in;
      r_m      <= bus.modulus;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == ST_SUB) begin
      r_d[w_lsb +: CHUNK] <= w_d;
      r_borrow            <= w_bout;
      r_cnt               <= w_last ? '0 : r_cnt + 1'b1;
    end else if (r_state == ST_SEL) begin
      r_result <= w_ge ? r_d : r_s[WIDTH-1:0];
    end else begin
      r_result <= r_result;
    end
  end

  // Status flags registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_SUB) | (w_state_nxt == ST_SEL);
      r_done <= (w_state_nxt == ST_DONE);
    end
  end

  assign bus.result = r_result;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule

// File: tb/tb_mod_reduce_stage.sv
// Self-checking bench for mod_reduce_stage against an arithmetic S mod M reference.
module tb_mod_reduce_stage;
  import mod_reduce_stage_pkg::*;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  mod_reduce_stage_if bus();

  mod_reduce_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  localparam logic [WIDTH-1:0] P256 =
    384'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

  function automatic logic [WIDTH-1:0] golden(input logic [WIDTH:0] s, input logic [WIDTH-1:0] m);
    logic [WIDTH+1:0] ws;
    logic [WIDTH+1:0] wm;
    logic [WIDTH+1:0] wd;
    ws = {1'b0, s};
    wm = {2'b00, m};
    wd = (ws >= wm) ? ws - wm : ws;
    return wd[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] rand_w();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < WIDTH / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [WIDTH:0] rand_s(input logic [WIDTH-1:0] m);
    logic [WIDTH+1:0] r;
    logic [WIDTH+1:0] lim;
    logic [WIDTH+1:0] k;
    logic [WIDTH+1:0] s;
    k = {{(WIDTH-1){1'b0}}, 3'($urandom_range(0, 7))};
    lim = {1'b0, m, 1'b0};
    case ($urandom_range(0, 3))
      0:       s = {{(WIDTH-1){1'b0}}, 1'b0, 1'b0, 1'b0} | ({2'($urandom), rand_w()} % lim);
      1:       s = ({2'b00, m} > k) ? {2'b00, m} + k : {2'b00, m};
      2:       s = ({2'b00, m} >= k) ? {2'b00, m} - k : {2'b00, m};
      default: s = {2'b00, m};
    endcase
    return s[WIDTH:0];
  endfunction

  // Issue one operation; returns result, edges from accept to done, and busy cycles seen.
  task automatic do_op(input logic [WIDTH:0] s, input logic [WIDTH-1:0] m, input bit b2b,
                       output logic [WIDTH-1:0] res, output int lat, output int bcyc);
    bit got;
    if (!b2b) @(negedge clk);
    bus.start   = 1'b1;
    bus.sum_in  = s;
    bus.modulus = m;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.sum_in  = {1'b1, rand_w()};
    bus.modulus = rand_w();
    lat = 0; bcyc = 0; got = 1'b0; res = '0;
    while (!got && lat < 20) begin
      @(negedge clk);
      if (bus.busy) bcyc++;
      if (bus.done) begin
        got = 1'b1;
        res = bus.result;
      end else begin
        @(posedge clk);
        lat++;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.result !== '0) begin n_errors++; $display("FAIL reset_result: got %h expected 0", bus.result); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] res;
    int lat, bcyc;
    do_op({1'b0, P256} + 385'd5, P256, 1'b0, res, lat, bcyc);
    n_checks++;
    if (res !== 384'd5) begin n_errors++; $display("FAIL basic_result: got %h expected 5", res); end
    n_checks++;
    if (lat !== 7) begin n_errors++; $display("FAIL basic_latency: got %0d expected 7", lat); end
    n_checks++;
    if (bcyc !== NCHUNK + 1) begin n_errors++; $display("FAIL basic_busy: got %0d expected %0d", bcyc, NCHUNK + 1); end
  endtask

  task automatic test_boundaries();
    logic [WIDTH-1:0] res, m, exp;
    logic [WIDTH:0]   s;
    int lat, bcyc;
    m = rand_w() | 384'd1;
    do_op({1'b0, m} - 385'd1, m, 1'b0, res, lat, bcyc);
    exp = m - 384'd1;
    n_checks++;
    if (res !== exp) begin n_errors++; $display("FAIL below_m: got %h expected %h", res, exp); end
    do_op({1'b0, m}, m, 1'b0, res, lat, bcyc);
    n_checks++;
    if (res !== 384'd0) begin n_errors++; $display("FAIL equal_m: got %h expected 0", res); end
    // Carry bit set with all-ones modulus.
    m = '1;
    s = '1;
    s = s - 385'd2;
    exp = '1;
    exp = exp - 384'd1;
    do_op(s, m, 1'b0, res, lat, bcyc);
    n_checks++;
    if (res !== exp) begin n_errors++; $display("FAIL carry_bit: got %h expected %h", res, exp); end
    n_checks++;
    if (lat !== 7) begin n_errors++; $display("FAIL carry_latency: got %0d expected 7", lat); end
  endtask

  task automatic test_ignore_and_b2b();
    logic [WIDTH-1:0] m, res, exp_a, exp_b;
    logic [WIDTH:0]   s;
    int lat, bcyc, extra;
    bit got;
    m = rand_w() | 384'd1;
    s = rand_s(m);
    exp_a = golden(s, m);
    @(negedge clk);
    bus.start = 1'b1; bus.sum_in = s; bus.modulus = m;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.sum_in = {1'b0, ~m}; bus.modulus = m;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 4; got = 1'b0; res = '0;
    while (!got && lat < 20) begin
      @(negedge clk);
      if (bus.done) begin got = 1'b1; res = bus.result; end
      else begin @(posedge clk); lat++; end
    end
    n_checks++;
    if (res !== exp_a) begin n_errors++; $display("FAIL ignore_result: got %h expected %h", res, exp_a); end
    n_checks++;
    if (lat !== 7) begin n_errors++; $display("FAIL ignore_latency: got %0d expected 7", lat); end
    extra = 0;
    repeat (10) begin @(negedge clk); if (bus.done) extra++; end
    n_checks++;
    if (extra !== 0) begin n_errors++; $display("FAIL ignore_no_second_done: got %0d expected 0", extra); end
    // Second start presented during the DONE cycle.
    do_op(s, m, 1'b0, res, lat, bcyc);
    s = rand_s(m);
    exp_b = golden(s, m);
    do_op(s, m, 1'b1, res, lat, bcyc);
    n_checks++;
    if (res !== exp_b) begin n_errors++; $display("FAIL b2b_result: got %h expected %h", res, exp_b); end
    n_checks++;
    if (lat !== 7) begin n_errors++; $display("FAIL b2b_latency: got %0d expected 7", lat); end
  endtask

  task automatic test_abort();
    logic [WIDTH-1:0] res;
    int lat, bcyc, extra;
    @(negedge clk);
    bus.start = 1'b1; bus.sum_in = {1'b0, P256} + 385'd9; bus.modulus = P256;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (bus.result !== '0) begin n_errors++; $display("FAIL abort_result: got %h expected 0", bus.result); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_errors++; $display("FAIL abort_done: got %b expected 0", bus.done); end
    @(negedge clk);
    resetn = 1'b1;
    extra = 0;
    repeat (12) begin @(negedge clk); if (bus.done) extra++; end
    n_checks++;
    if (extra !== 0) begin n_errors++; $display("FAIL abort_no_done: got %0d expected 0", extra); end
    do_op({1'b0, P256} + 385'd1, P256, 1'b0, res, lat, bcyc);
    n_checks++;
    if (res !== 384'd1) begin n_errors++; $display("FAIL abort_next_op: got %h expected 1", res); end
  endtask

  task automatic test_random(input int n_ops);
    logic [WIDTH-1:0] m, res, exp;
    logic [WIDTH:0]   s;
    int lat, bcyc;
    bit b2b;
    b2b = 1'b0;
    for (int i = 0; i < n_ops; i++) begin
      m = rand_w();
      if (m == '0) m = 384'd1;
      s = rand_s(m);
      exp = golden(s, m);
      if (!b2b) repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(s, m, b2b, res, lat, bcyc);
      n_checks++;
      if (res !== exp || lat !== 7) begin
        n_errors++;
        $display("FAIL random_op %0d: got %h lat %0d expected %h lat 7", i, res, lat, exp);
      end
      b2b = (lat == 7) && ($urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.sum_in  = '0;
    bus.modulus = '0;
    test_reset();
    test_basic();
    test_boundaries();
    test_ignore_and_b2b();
    test_abort();
    test_random(1500);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
